x86_decode_seq: RTL and testbench
=================================

# x86_decode_seq

Byte-serial x86-64 instruction decode sequencer. It sits between the fetch byte stream and the decode/issue stage, and consumes one instruction byte per cycle. It tracks legacy and REX prefixes, steers the opcode byte into the one-byte or two-byte (0F-escape) instruction-info table, and uses the returned 23-bit entry to walk ModRM, SIB, displacement and immediate bytes. When the instruction is complete it emits a single decoded record over a valid/ready handshake.

## Interface
- MAX_LEN, 15: architectural instruction length limit in bytes.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- byte_valid  in  1  byte_data holds a fetched byte.
- byte_data  in  8  next instruction byte.
- byte_ready  out  1  sequencer accepts byte_data this cycle.
- tbl_sel  out  1  table select: 0 = one-byte table, 1 = two-byte (0F) table.
- tbl_idx  out  8  table index; equals byte_data, combinational.
- tbl_entry  in  23  combinational table read, with fields:
  - [22:21] numop
  - [20:19] op1 type
  - [18:17] op2 type
  - [16:15] sizeop1
  - [14:13] sizeop2
  - [12:9] op1regno
  - [8:5] op2regno
  - [4:0] group
- out_valid  out  1  decoded record valid.
- out_ready  in  1  downstream accepts record.
- out_opcode  out  9  {escape, opcode byte}.
- out_entry  out  23  latched tbl_entry.
- out_pfx  out  3  {opsize 66, rep F3, repne F2}.
- out_rex  out  5  {present, W, R, X, B}.
- out_modrm, out_sib  out  8 each  raw bytes; 0 if absent.
- out_disp, out_imm  out  32 each  little-endian raw value; unused upper bits 0.
- out_len  out  4  total bytes consumed.
- out_err  out  1  length overflow.

## Operation
- States: PFX, ESC, MODRM, SIB, DISP, IMM, DONE.
- Operand type encoding: 00 fixed/none, 01 ModRM r/m, 10 ModRM reg, 11 immediate.
- Size encoding: 00 byte, 01 word, 10 dword, 11 qword. Immediate length is 1, 2, 4 or 4 bytes respectively.
- PFX state:
  - 66/F2/F3 set the matching out_pfx bit and clear any REX seen so far.
  - 40–4F latch out_rex = {1, byte[3:0]}.
  - 0F sets escape and moves to ESC with tbl_sel = 1.
  - Any other byte is a one-byte opcode (tbl_sel = 0); tbl_entry is latched on acceptance.
- ESC state: the accepted byte is the two-byte opcode; tbl_entry is latched.
- After the opcode is latched:
  - need_modrm = (numop ≥ 1 and op1 type ∈ {01, 10}) or (numop = 2 and op2 type ∈ {01, 10}).
  - imm_len comes from op2 when numop = 2 and op2 type = 11, else from op1 when numop ≥ 1 and op1 type = 11, else 0.
  - Next state is MODRM if need_modrm, else IMM if imm_len > 0, else DONE.
- MODRM state:
  - mod ≠ 11 and rm = 100 → SIB.
  - mod = 01 → disp 1 byte.
  - mod = 10, or (mod = 00 and rm = 101) → disp 4 bytes.
- SIB state: base = 101 with mod = 00 forces disp 4 bytes.
- DISP, then IMM: bytes are shifted in little-endian via a byte counter. The state is skipped when its length is 0.
- Length counter increments on every accepted byte. If it reaches MAX_LEN and more bytes are still required: out_err = 1, out_len = MAX_LEN, go to DONE.
- DONE state:
  - out_valid = 1 and all out_* are held stable.
  - On out_valid and out_ready: clear all accumulators and return to PFX.

## Timing
- byte_ready = !reset and state ≠ DONE (combinational).
- A byte is consumed on a cycle with byte_valid and byte_ready. At most one byte is consumed per cycle.
- tbl_entry is sampled in the same cycle the opcode byte is accepted. No lookup bubble.
- out_valid rises on the clock edge that accepts the last byte, and is registered.
- An N-byte instruction occupies N cycles plus at least one DONE cycle. The next instruction's first byte is accepted the cycle after the out handshake.
- byte_valid = 0 stalls in place with no state change.
- Reset value: state PFX, out_valid 0, every out_* field 0, counters 0.
- Reset mid-instruction discards all partial state. The next accepted byte is treated as the first byte of a new instruction.
- out_ready low in DONE holds the record and byte_ready = 0 indefinitely.

## Test plan
- 90 with entry 0 → out_valid 1 after 1 byte accepted; out_opcode 0x090, out_len 1, out_modrm 0, out_err 0.
- 48 0F AF C1, two-byte entry numop 2, op1 10, op2 01:
  - tbl_sel = 1 on the AF cycle.
  - out_rex 5'b11000, out_opcode 0x1AF, out_modrm C1, out_len 4.
- 8B 44 24 08, entry op1 10, op2 01: out_sib 0x24, out_disp 0x00000008, out_len 4.
- 81 C0 78 56 34 12, entry numop 2, op1 01, op2 11, sizeop2 10: out_imm 0x12345678, out_len 6.
- Prefix and limit cases:
  - 48 66 90 → out_rex 0, out_pfx 3'b100, out_len 3.
  - 15 consecutive 66 bytes → out_err 1, out_len 15.
- Back-pressure and reset:
  - Hold out_ready low 3 cycles → record stable and byte_ready 0; accepted on the 4th cycle.
  - Assert reset after 8B 44 → out_valid stays 0; next 90 decodes with out_len 1.

Source files
------------

// File: rtl/x86_decode_seq.sv
// Byte-serial x86-64 decode sequencer: prefixes, opcode/0F escape, ModRM, SIB, disp, imm -> one record.
// Record valid on the edge accepting the last byte; byte_ready low while the record waits for out_ready.
module x86_decode_seq #(
  parameter int MAX_LEN = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        tbl_sel,
  output logic [7:0]  tbl_idx,
  input  logic [22:0] tbl_entry,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [8:0]  out_opcode,
  output logic [22:0] out_entry,
  output logic [2:0]  out_pfx,
  output logic [4:0]  out_rex,
  output logic [7:0]  out_modrm,
  output logic [7:0]  out_sib,
  output logic [31:0] out_disp,
  output logic [31:0] out_imm,
  output logic [3:0]  out_len,
  output logic        out_err
);

  typedef enum logic [2:0] {PFX, ESC, MODRM, SIB, DISP, IMM, DONE} state_t;

  localparam logic [3:0] LEN_LAST = 4'(MAX_LEN - 1);

  state_t      state, nxt;
  logic        escape_q;
  logic [7:0]  opcode_q;
  logic [22:0] entry_q;
  logic [2:0]  pfx_q;
  logic [4:0]  rex_q;
  logic [7:0]  modrm_q;
  logic [7:0]  sib_q;
  logic [31:0] disp_q;
  logic [31:0] imm_q;
  logic [3:0]  len_q;
  logic        err_q;
  logic        vld_q;
  logic [2:0]  disp_len;
  logic [2:0]  imm_len;
  logic [2:0]  bcnt;

  logic        accept;
  logic        overflow;
  logic [1:0]  numop, op1t, op2t;
  logic        tbl_need_modrm;
  logic [2:0]  tbl_imm_len;
  logic        is_pfx, is_rex, is_esc;
  logic        m_sib;
  logic [2:0]  m_dlen, s_dlen;
  logic        disp_last, imm_last;
  state_t      opc_nxt, after_imm;

  function automatic logic [2:0] imm_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   imm_bytes = 3'd1;
      2'b01:   imm_bytes = 3'd2;
      default: imm_bytes = 3'd4;
    endcase
  endfunction

  assign byte_ready = !reset && (state != DONE);
  assign accept     = byte_valid && byte_ready;
  assign tbl_sel    = (state == ESC);
  assign tbl_idx    = byte_data;

  assign numop = tbl_entry[22:21];
  assign op1t  = tbl_entry[20:19];
  assign op2t  = tbl_entry[18:17];

  // Operand types 01/10 both live in the ModRM byte; 11 is an immediate.
  assign tbl_need_modrm = ((numop != 2'd0) && (op1t == 2'b01 || op1t == 2'b10)) ||
                          ((numop == 2'd2) && (op2t == 2'b01 || op2t == 2'b10));
  assign tbl_imm_len = ((numop == 2'd2) && (op2t == 2'b11)) ? imm_bytes(tbl_entry[14:13]) :
                       ((numop != 2'd0) && (op1t == 2'b11)) ? imm_bytes(tbl_entry[16:15]) :
                       3'd0;

  assign is_pfx = (byte_data == 8'h66) || (byte_data == 8'hF2) || (byte_data == 8'hF3);
  assign is_rex = (byte_data[7:4] == 4'h4);
  assign is_esc = (byte_data == 8'h0F);

  assign m_sib  = (byte_data[7:6] != 2'b11) && (byte_data[2:0] == 3'b100);
  assign m_dlen = (byte_data[7:6] == 2'b01) ? 3'd1 :
                  ((byte_data[7:6] == 2'b10) ||
                   (byte_data[7:6] == 2'b00 && byte_data[2:0] == 3'b101)) ? 3'd4 : 3'd0;
  assign s_dlen = (byte_data[2:0] == 3'b101 && modrm_q[7:6] == 2'b00) ? 3'd4 : disp_len;

  assign disp_last = (bcnt + 3'd1 == disp_len);
  assign imm_last  = (bcnt + 3'd1 == imm_len);

  assign opc_nxt   = tbl_need_modrm ? MODRM : ((tbl_imm_len != 3'd0) ? IMM : DONE);
  assign after_imm = (imm_len != 3'd0) ? IMM : DONE;

  always_ff @(posedge clk) begin
    if (reset) state <= PFX;
    else       state <= nxt;
  end

  always_comb begin
    nxt      = state;
    overflow = 1'b0;
    case (state)
      PFX: if (accept) begin
        if (is_pfx || is_rex) nxt = PFX;
        else if (is_esc)      nxt = ESC;
        else                  nxt = opc_nxt;
      end
      ESC:   if (accept) nxt = opc_nxt;
      MODRM: if (accept) nxt = m_sib ? SIB : ((m_dlen != 3'd0) ? DISP : after_imm);
      SIB:   if (accept) nxt = (s_dlen != 3'd0) ? DISP : after_imm;
      DISP:  if (accept && disp_last) nxt = after_imm;
      IMM:   if (accept && imm_last) nxt = DONE;
      DONE:  if (out_ready) nxt = PFX;
      default: nxt = PFX;
    endcase
    // Last architectural byte taken but the instruction still wants more.
    if (accept && (len_q == LEN_LAST) && (nxt != DONE)) begin
      overflow = 1'b1;
      nxt      = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (vld_q && out_ready)) begin
      escape_q <= 1'b0;
      opcode_q <= 8'd0;
      entry_q  <= 23'd0;
      pfx_q    <= 3'd0;
      rex_q    <= 5'd0;
      modrm_q  <= 8'd0;
      sib_q    <= 8'd0;
      disp_q   <= 32'd0;
      imm_q    <= 32'd0;
      len_q    <= 4'd0;
      err_q    <= 1'b0;
      vld_q    <= 1'b0;
      disp_len <= 3'd0;
      imm_len  <= 3'd0;
      bcnt     <= 3'd0;
    end else if (accept) begin
      len_q <= len_q + 4'd1;
      if (nxt == DONE) vld_q <= 1'b1;
      if (overflow)    err_q <= 1'b1;
      case (state)
        PFX: begin
          if (byte_data == 8'h66) begin
            pfx_q[2] <= 1'b1;
            rex_q    <= 5'd0;
          end else if (byte_data == 8'hF3) begin
            pfx_q[1] <= 1'b1;
            rex_q    <= 5'd0;
          end else if (byte_data == 8'hF2) begin
            pfx_q[0] <= 1'b1;
            rex_q    <= 5'd0;
          end else if (is_rex) begin
            rex_q <= {1'b1, byte_data[3:0]};
          end else if (is_esc) begin
            escape_q <= 1'b1;
          end else begin
            opcode_q <= byte_data;
            entry_q  <= tbl_entry;
            imm_len  <= tbl_imm_len;
          end
        end
        ESC: begin
          opcode_q <= byte_data;
          entry_q  <= tbl_entry;
          imm_len  <= tbl_imm_len;
        end
        MODRM: begin
          modrm_q  <= byte_data;
          disp_len <= m_dlen;
        end
        SIB: begin
          sib_q    <= byte_data;
          disp_len <= s_dlen;
        end
        DISP: begin
          disp_q[{bcnt[1:0], 3'b000} +: 8] <= byte_data;
          bcnt <= disp_last ? 3'd0 : bcnt + 3'd1;
        end
        IMM: begin
          imm_q[{bcnt[1:0], 3'b000} +: 8] <= byte_data;
          bcnt <= imm_last ? 3'd0 : bcnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign out_valid  = vld_q;
  assign out_opcode = {escape_q, opcode_q};
  assign out_entry  = entry_q;
  assign out_pfx    = pfx_q;
  assign out_rex    = rex_q;
  assign out_modrm  = modrm_q;
  assign out_sib    = sib_q;
  assign out_disp   = disp_q;
  assign out_imm    = imm_q;
  assign out_len    = len_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_x86_decode_seq.sv
// Directed bench for x86_decode_seq with a tiny instruction-info table model.
module tb_x86_decode_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        tbl_sel;
  logic [7:0]  tbl_idx;
  logic [22:0] tbl_entry;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_opcode;
  logic [22:0] out_entry;
  logic [2:0]  out_pfx;
  logic [4:0]  out_rex;
  logic [7:0]  out_modrm;
  logic [7:0]  out_sib;
  logic [31:0] out_disp;
  logic [31:0] out_imm;
  logic [3:0]  out_len;
  logic        out_err;

  int vecs = 0;
  int errs = 0;

  // numop 2, op1 reg, op2 r/m
  localparam logic [22:0] E_RM  = {2'd2, 2'b10, 2'b01, 2'b10, 2'b10, 4'd0, 4'd0, 5'd0};
  // numop 2, op1 r/m, op2 imm, sizeop2 dword
  localparam logic [22:0] E_IMM = {2'd2, 2'b01, 2'b11, 2'b10, 2'b10, 4'd0, 4'd0, 5'd0};

  x86_decode_seq #(.MAX_LEN(15)) dut (
    .clk(clk), .reset(reset),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .tbl_sel(tbl_sel), .tbl_idx(tbl_idx), .tbl_entry(tbl_entry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_entry(out_entry), .out_pfx(out_pfx), .out_rex(out_rex),
    .out_modrm(out_modrm), .out_sib(out_sib), .out_disp(out_disp), .out_imm(out_imm),
    .out_len(out_len), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] lookup(input logic sel, input logic [7:0] idx);
    if (sel && idx == 8'hAF)  return E_RM;
    if (!sel && idx == 8'h8B) return E_RM;
    if (!sel && idx == 8'h81) return E_IMM;
    return 23'd0;
  endfunction

  always_comb tbl_entry = lookup(tbl_sel, tbl_idx);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [7:0] b);
    int n;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("byte_ready_wait", 32'(byte_ready), 32'd1);
  endtask

  task automatic consume();
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    present(b);
    consume();
  endtask

  task automatic release_rec();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("valid_cleared", 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", 32'(byte_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_len", 32'(out_len), 32'd0);
    chk("rst_opcode", 32'(out_opcode), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_ready", 32'(byte_ready), 32'd1);

    // NOP
    send(8'h90);
    @(negedge clk);
    chk("nop_valid", 32'(out_valid), 32'd1);
    chk("nop_opcode", 32'(out_opcode), 32'h090);
    chk("nop_len", 32'(out_len), 32'd1);
    chk("nop_modrm", 32'(out_modrm), 32'd0);
    chk("nop_err", 32'(out_err), 32'd0);
    chk("nop_ready_low", 32'(byte_ready), 32'd0);
    release_rec();

    // REX.W imul r, r/m (0F AF)
    send(8'h48);
    present(8'h0F);
    chk("esc_tbl_sel0", 32'(tbl_sel), 32'd0);
    consume();
    present(8'hAF);
    chk("af_tbl_sel", 32'(tbl_sel), 32'd1);
    chk("af_tbl_idx", 32'(tbl_idx), 32'hAF);
    consume();
    send(8'hC1);
    @(negedge clk);
    chk("imul_valid", 32'(out_valid), 32'd1);
    chk("imul_rex", 32'(out_rex), 32'h18);
    chk("imul_opcode", 32'(out_opcode), 32'h1AF);
    chk("imul_modrm", 32'(out_modrm), 32'hC1);
    chk("imul_len", 32'(out_len), 32'd4);
    chk("imul_entry", 32'(out_entry), 32'(E_RM));
    release_rec();

    // mov r, [rsp+8] : ModRM + SIB + disp8
    send(8'h8B); send(8'h44); send(8'h24); send(8'h08);
    @(negedge clk);
    chk("mov_valid", 32'(out_valid), 32'd1);
    chk("mov_modrm", 32'(out_modrm), 32'h44);
    chk("mov_sib", 32'(out_sib), 32'h24);
    chk("mov_disp", out_disp, 32'h0000_0008);
    chk("mov_imm", out_imm, 32'd0);
    chk("mov_len", 32'(out_len), 32'd4);
    release_rec();

    // add r/m, imm32 with an input stall in the middle
    send(8'h81); send(8'hC0); send(8'h78);
    repeat (2) @(negedge clk);
    chk("stall_valid", 32'(out_valid), 32'd0);
    chk("stall_len", 32'(out_len), 32'd3);
    send(8'h56); send(8'h34); send(8'h12);
    @(negedge clk);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_imm", out_imm, 32'h1234_5678);
    chk("add_disp", out_disp, 32'd0);
    chk("add_len", 32'(out_len), 32'd6);
    chk("add_entry", 32'(out_entry), 32'(E_IMM));
    release_rec();

    // 66 after REX drops the REX
    send(8'h48); send(8'h66); send(8'h90);
    @(negedge clk);
    chk("pfx_valid", 32'(out_valid), 32'd1);
    chk("pfx_rex", 32'(out_rex), 32'd0);
    chk("pfx_bits", 32'(out_pfx), 32'b100);
    chk("pfx_len", 32'(out_len), 32'd3);
    release_rec();

    // Length limit: 15 prefixes and no opcode
    for (int i = 0; i < 14; i++) send(8'h66);
    @(negedge clk);
    chk("lim14_valid", 32'(out_valid), 32'd0);
    send(8'h66);
    @(negedge clk);
    chk("lim_valid", 32'(out_valid), 32'd1);
    chk("lim_err", 32'(out_err), 32'd1);
    chk("lim_len", 32'(out_len), 32'd15);
    release_rec();
    chk("lim_err_cleared", 32'(out_err), 32'd0);

    // Back-pressure: record held for 3 cycles
    send(8'h90);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_ready", 32'(byte_ready), 32'd0);
      chk("bp_opcode", 32'(out_opcode), 32'h090);
      chk("bp_len", 32'(out_len), 32'd1);
    end
    release_rec();
    chk("bp_ready_back", 32'(byte_ready), 32'd1);
    chk("bp_len_cleared", 32'(out_len), 32'd0);

    // Reset mid-instruction
    send(8'h8B); send(8'h44);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(byte_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_len", 32'(out_len), 32'd0);
    chk("mid_rst_modrm", 32'(out_modrm), 32'd0);
    send(8'h90);
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_opcode", 32'(out_opcode), 32'h090);
    chk("post_rst_len", 32'(out_len), 32'd1);
    chk("post_rst_entry", 32'(out_entry), 32'd0);
    release_rec();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
